// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding and instruction geometry.
package cpu_pkg;

  localparam int PC_W        = 32;
  localparam int INSTR_W     = 32;
  localparam int INSTR_BYTES = 4;

  // Fetch sequencer states (2-bit encoding, 2'b11 unused).
  typedef enum logic [1:0] {
    IF_IDLE  = 2'b00,
    IF_FETCH = 2'b01,
    IF_HOLD  = 2'b10
  } if_state_e;

endpackage : cpu_pkg

// File: rtl/ifetch_unit.sv
// Instruction-fetch sequencer: issues one imem read at a time from pc_in,
// buffers the returned word for decode and steers the PC register.
//
// Handshakes:
//   imem: imem_req stays high in FETCH until a single-cycle imem_ack.
//   decode: a transfer happens on a rising clk edge where if_valid and
//   if_ready are both high; if_instr/if_pc are stable while if_valid waits.
// The FSM state is held in state_q for hierarchical observation.
module ifetch_unit
  import cpu_pkg::*;
#(
  parameter int PC_W    = cpu_pkg::PC_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_W-1:0]    pc_in,
  output logic               pc_en,
  output logic [PC_W-1:0]    pc_next,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_target,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc
);

  if_state_e          state_q, state_d;
  logic               squash_q, squash_d;
  logic [PC_W-1:0]    redir_buf_q, redir_buf_d;
  logic [INSTR_W-1:0] if_instr_q, if_instr_d;
  logic [PC_W-1:0]    if_pc_q, if_pc_d;
  logic [PC_W-1:0]    target_aligned;
  logic               pc_en_raw;
  logic [PC_W-1:0]    pc_next_raw;

  // Redirect targets are always word aligned; low two bits are cleared.
  assign target_aligned = redirect_target & ~PC_W'(3);

  // Next-state, buffer updates and Mealy PC-control decode.
  always_comb begin
    state_d     = state_q;
    squash_d    = squash_q;
    redir_buf_d = redir_buf_q;
    if_instr_d  = if_instr_q;
    if_pc_d     = if_pc_q;
    pc_en_raw   = 1'b0;
    pc_next_raw = '0;
    case (state_q)
      IF_IDLE: begin
        if (redirect_valid) begin
          pc_en_raw   = 1'b1;
          pc_next_raw = target_aligned;
        end else begin
          state_d = IF_FETCH;
        end
      end
      IF_FETCH: begin
        if (imem_ack) begin
          if (squash_q || redirect_valid) begin
            // Returned word belongs to a squashed path; a same-cycle redirect wins.
            pc_en_raw   = 1'b1;
            pc_next_raw = redirect_valid ? target_aligned : redir_buf_q;
            squash_d    = 1'b0;
            state_d     = IF_IDLE;
          end else begin
            if_instr_d = imem_rdata;
            if_pc_d    = pc_in;
            state_d    = IF_HOLD;
          end
        end else if (redirect_valid) begin
          // Cannot cancel the outstanding read; remember where to go after it.
          redir_buf_d = target_aligned;
          squash_d    = 1'b1;
        end
      end
      IF_HOLD: begin
        if (redirect_valid) begin
          pc_en_raw   = 1'b1;
          pc_next_raw = target_aligned;
          state_d     = IF_IDLE;
        end else if (if_ready) begin
          pc_en_raw   = 1'b1;
          pc_next_raw = if_pc_q + PC_W'(INSTR_BYTES);
          state_d     = IF_FETCH;
        end
      end
      default: state_d = IF_IDLE;
    endcase
  end

  // State and buffer registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IF_IDLE;
      squash_q    <= 1'b0;
      redir_buf_q <= '0;
      if_instr_q  <= '0;
      if_pc_q     <= '0;
    end else begin
      state_q     <= state_d;
      squash_q    <= squash_d;
      redir_buf_q <= redir_buf_d;
      if_instr_q  <= if_instr_d;
      if_pc_q     <= if_pc_d;
    end
  end

  // All outputs, including the combinational ones, read zero while rst is high.
  assign imem_req  = ~rst & (state_q == IF_FETCH);
  assign imem_addr = rst ? '0 : pc_in;
  assign if_valid  = ~rst & (state_q == IF_HOLD) & ~redirect_valid;
  assign if_instr  = rst ? '0 : if_instr_q;
  assign if_pc     = rst ? '0 : if_pc_q;
  assign pc_en     = ~rst & pc_en_raw;
  assign pc_next   = rst ? '0 : pc_next_raw;

endmodule : ifetch_unit

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit with a behavioural PC register and a scripted memory.
module tb_ifetch_unit;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;

  logic               clk;
  logic               rst;
  logic [PC_W-1:0]    pc_reg;
  logic               pc_en;
  logic [PC_W-1:0]    pc_next;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_target;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               if_valid;
  logic               if_ready;
  logic [INSTR_W-1:0] if_instr;
  logic [PC_W-1:0]    if_pc;

  logic [INSTR_W-1:0] exp_q[$];
  logic [PC_W-1:0]    exp_pc_q[$];
  int checks;
  int errors;

  ifetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_reg), .pc_en(pc_en), .pc_next(pc_next),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register the fetch unit drives.
  always @(posedge clk or posedge rst) begin
    if (rst) pc_reg <= '0;
    else if (pc_en) pc_reg <= pc_next;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  // Driver: advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every decode transfer must match the next expected word.
  task automatic monitor();
    logic [INSTR_W-1:0] ei;
    logic [PC_W-1:0]    ep;
    forever begin
      @(negedge clk);
      if (!rst && if_valid && if_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_delivery: got instr=%h pc=%h, want no transfer", if_instr, if_pc);
        end else begin
          ei = exp_q.pop_front();
          ep = exp_pc_q.pop_front();
          if (if_instr !== ei || if_pc !== ep) begin
            errors++;
            $display("FAIL delivery: got instr=%h pc=%h, want instr=%h pc=%h", if_instr, if_pc, ei, ep);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect_valid = 1'b0; redirect_target = '0;
    imem_ack = 1'b0; imem_rdata = '0; if_ready = 1'b0;
    repeat (3) tick();
    checks++;
    if ({imem_req, pc_en, if_valid, pc_next, imem_addr, if_instr, if_pc} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b en=%b v=%b nxt=%h addr=%h ins=%h pc=%h, want all 0",
               imem_req, pc_en, if_valid, pc_next, imem_addr, if_instr, if_pc);
    end
    tick(); rst = 1'b0; #1;
    checks++;
    if (imem_req !== 1'b0 || pc_en !== 1'b0 || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got req=%b en=%b v=%b, want 0 0 0", imem_req, pc_en, if_valid);
    end
    tick(); #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL first_req: got req=%b addr=%h, want 1 00000000", imem_req, imem_addr);
    end
    tick();
    tick(); imem_ack = 1'b1; imem_rdata = 32'h2008_0005;
    exp_q.push_back(32'h2008_0005); exp_pc_q.push_back(32'h0);
    #1;
    checks++;
    if (imem_req !== 1'b1) begin
      errors++;
      $display("FAIL req_held: got %b, want 1", imem_req);
    end
    tick(); imem_ack = 1'b0; #1;
    checks++;
    if (if_valid !== 1'b1 || if_instr !== 32'h2008_0005 || if_pc !== 32'h0) begin
      errors++;
      $display("FAIL first_hold: got v=%b ins=%h pc=%h, want 1 20080005 00000000", if_valid, if_instr, if_pc);
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 5; i++) begin
      tick(); #1;
      checks++;
      if (if_valid !== 1'b1 || if_instr !== 32'h2008_0005 || pc_en !== 1'b0 || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL stall: got v=%b ins=%h en=%b req=%b, want 1 20080005 0 0", if_valid, if_instr, pc_en, imem_req);
      end
    end
    tick(); if_ready = 1'b1; #1;
    checks++;
    if (pc_en !== 1'b1 || pc_next !== 32'h4) begin
      errors++;
      $display("FAIL accept_pc: got en=%b nxt=%h, want 1 00000004", pc_en, pc_next);
    end
    tick(); if_ready = 1'b0; #1;
    checks++;
    if (pc_en !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h4) begin
      errors++;
      $display("FAIL next_req: got en=%b req=%b addr=%h, want 0 1 00000004", pc_en, imem_req, imem_addr);
    end
  endtask

  task automatic test_hold_redirect();
    imem_ack = 1'b1; imem_rdata = 32'h1111_1111;  // dropped by the redirect below
    tick(); imem_ack = 1'b0;
    redirect_valid = 1'b1; redirect_target = 32'h103; if_ready = 1'b1; #1;
    checks++;
    if (if_valid !== 1'b0 || pc_en !== 1'b1 || pc_next !== 32'h100) begin
      errors++;
      $display("FAIL hold_redirect: got v=%b en=%b nxt=%h, want 0 1 00000100", if_valid, pc_en, pc_next);
    end
    tick(); redirect_valid = 1'b0; if_ready = 1'b0; #1;
    checks++;
    if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_redirect_idle: got req=%b v=%b, want 0 0", imem_req, if_valid);
    end
    tick(); #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      errors++;
      $display("FAIL hold_redirect_req: got req=%b addr=%h, want 1 00000100", imem_req, imem_addr);
    end
  endtask

  task automatic test_fetch_redirect();
    tick(); redirect_valid = 1'b1; redirect_target = 32'h200; #1;
    checks++;
    if (pc_en !== 1'b0 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL fetch_redirect_hold: got en=%b req=%b, want 0 1", pc_en, imem_req);
    end
    tick(); redirect_valid = 1'b0;
    tick();
    tick(); imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
    checks++;
    if (pc_en !== 1'b1 || pc_next !== 32'h200 || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL squash_ack: got en=%b nxt=%h v=%b, want 1 00000200 0", pc_en, pc_next, if_valid);
    end
    tick(); imem_ack = 1'b0; #1;
    checks++;
    if (if_valid !== 1'b0 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL squash_idle: got v=%b req=%b, want 0 0", if_valid, imem_req);
    end
    tick(); #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      errors++;
      $display("FAIL squash_refetch: got req=%b addr=%h, want 1 00000200", imem_req, imem_addr);
    end
    imem_ack = 1'b1; imem_rdata = 32'hCAFE_0001;
    exp_q.push_back(32'hCAFE_0001); exp_pc_q.push_back(32'h200);
    tick(); imem_ack = 1'b0; if_ready = 1'b1; #1;
    checks++;
    if (if_valid !== 1'b1 || pc_en !== 1'b1 || pc_next !== 32'h204) begin
      errors++;
      $display("FAIL refetch_accept: got v=%b en=%b nxt=%h, want 1 1 00000204", if_valid, pc_en, pc_next);
    end
    tick(); if_ready = 1'b0; #1;
  endtask

  task automatic test_wrap();
    imem_ack = 1'b1; imem_rdata = 32'h0000_0013;  // dropped by the redirect below
    tick(); imem_ack = 1'b0; redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFF; #1;
    checks++;
    if (pc_en !== 1'b1 || pc_next !== 32'hFFFF_FFFC || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL align_target: got en=%b nxt=%h v=%b, want 1 fffffffc 0", pc_en, pc_next, if_valid);
    end
    tick(); redirect_valid = 1'b0;
    tick(); #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_req: got req=%b addr=%h, want 1 fffffffc", imem_req, imem_addr);
    end
    imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
    exp_q.push_back(32'h0050_0093); exp_pc_q.push_back(32'hFFFF_FFFC);
    tick(); imem_ack = 1'b0; if_ready = 1'b1; #1;
    checks++;
    if (if_pc !== 32'hFFFF_FFFC || pc_en !== 1'b1 || pc_next !== 32'h0) begin
      errors++;
      $display("FAIL wrap_next: got pc=%h en=%b nxt=%h, want fffffffc 1 00000000", if_pc, pc_en, pc_next);
    end
    tick(); if_ready = 1'b0; #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL wrap_fetch: got req=%b addr=%h, want 1 00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_back_to_back();
    logic [PC_W-1:0]    pc_exp;
    logic [INSTR_W-1:0] data;
    pc_exp = 32'h0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== pc_exp) begin
        errors++;
        $display("FAIL b2b_req[%0d]: got req=%b addr=%h, want 1 %h", i, imem_req, imem_addr, pc_exp);
      end
      repeat ($urandom_range(0, 2)) tick();
      data = $urandom;
      imem_ack = 1'b1; imem_rdata = data;
      exp_q.push_back(data); exp_pc_q.push_back(pc_exp);
      tick(); imem_ack = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
      if_ready = 1'b1; #1;
      checks++;
      if (pc_en !== 1'b1 || pc_next !== pc_exp + 32'd4) begin
        errors++;
        $display("FAIL b2b_next[%0d]: got en=%b nxt=%h, want 1 %h", i, pc_en, pc_next, pc_exp + 32'd4);
      end
      tick(); if_ready = 1'b0; #1;
      pc_exp = pc_exp + 32'd4;
    end
  endtask

  task automatic test_reset_mid_fetch();
    rst = 1'b1; #1;
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || pc_en !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got req=%b addr=%h en=%b, want 0 00000000 0", imem_req, imem_addr, pc_en);
    end
    tick();
    tick(); rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBADB_AD00; #1;
    checks++;
    if (if_valid !== 1'b0 || pc_en !== 1'b0 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL stale_ack: got v=%b en=%b req=%b, want 0 0 0", if_valid, pc_en, imem_req);
    end
    tick(); imem_ack = 1'b0; #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL fresh_req: got req=%b addr=%h v=%b, want 1 00000000 0", imem_req, imem_addr, if_valid);
    end
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    exp_q.push_back(32'h1234_5678); exp_pc_q.push_back(32'h0);
    tick(); imem_ack = 1'b0; #1;
    checks++;
    if (if_valid !== 1'b1 || if_instr !== 32'h1234_5678) begin
      errors++;
      $display("FAIL fresh_hold: got v=%b ins=%h, want 1 12345678", if_valid, if_instr);
    end
    if_ready = 1'b1;
    tick(); if_ready = 1'b0; #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    fork
      monitor();
    join_none
    test_reset();
    test_backpressure();
    test_hold_redirect();
    test_fetch_redirect();
    test_wrap();
    test_back_to_back();
    test_reset_mid_fetch();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d undelivered, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ifetch_unit
